// File: rtl/score_pkg.sv
// Shared state encoding and default sizing for the score tracker.
package score_pkg;

  localparam int DEF_SCORE_W   = 8;
  localparam int DEF_SCORE_MAX = 99;
  localparam int DEF_MAX_LIVES = 3;
  localparam int DEF_LIVES_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Score register: clears on request, counts up by one and sticks at SCORE_MAX.
module sat_counter
  import score_pkg::*;
#(
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int SCORE_MAX = DEF_SCORE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != SCORE_W'(SCORE_MAX))) begin
      value <= value + SCORE_W'(1);
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Tracks score and lives for one game and emits a single end-of-game pulse:
// newHighScore_s when the final score beats the stored best, died_s otherwise.
module score_tracker
  import score_pkg::*;
#(
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int SCORE_MAX = DEF_SCORE_MAX,
  parameter int MAX_LIVES = DEF_MAX_LIVES,
  parameter int LIVES_W   = DEF_LIVES_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startGame_s,
  input  logic               hit_s,
  input  logic               miss_s,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] highScore,
  output logic [LIVES_W-1:0] lives,
  output logic               playing_s,
  output logic               newHighScore_s,
  output logic               died_s
);

  state_t             state, state_next;
  logic [LIVES_W-1:0] lives_next;
  logic [SCORE_W-1:0] high_next;
  logic               new_high_next;
  logic               died_next;
  logic               score_clear;
  logic               score_inc;

  sat_counter #(
    .SCORE_W   (SCORE_W),
    .SCORE_MAX (SCORE_MAX)
  ) u_score (
    .clk   (clk),
    .rst   (rst),
    .clear (score_clear),
    .inc   (score_inc),
    .value (score)
  );

  always_comb begin
    state_next    = state;
    lives_next    = lives;
    high_next     = highScore;
    new_high_next = 1'b0;
    died_next     = 1'b0;
    score_clear   = 1'b0;
    score_inc     = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (startGame_s) begin
          state_next  = PLAY;
          score_clear = 1'b1;
          lives_next  = LIVES_W'(MAX_LIVES);
        end
      end
      PLAY: begin
        // A restart wins over any hit/miss arriving in the same cycle.
        if (startGame_s) begin
          score_clear = 1'b1;
          lives_next  = LIVES_W'(MAX_LIVES);
        end else begin
          score_inc = hit_s;
          if (miss_s) begin
            lives_next = lives - LIVES_W'(1);
            if (lives == LIVES_W'(1)) begin
              state_next = CHECK;
            end
          end
        end
      end
      CHECK: begin
        state_next = OVER;
        if (score > highScore) begin
          high_next     = score;
          new_high_next = 1'b1;
        end else begin
          died_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      lives          <= '0;
      highScore      <= '0;
      playing_s      <= 1'b0;
      newHighScore_s <= 1'b0;
      died_s         <= 1'b0;
    end else begin
      state          <= state_next;
      lives          <= lives_next;
      highScore      <= high_next;
      playing_s      <= (state_next == PLAY);
      newHighScore_s <= new_high_next;
      died_s         <= died_next;
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Scenario bench for score_tracker; end-of-game pulses are matched against a queue of expected events.
module tb_score_tracker;

  logic       clk;
  logic       rst;
  logic       start_game;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] lives;
  logic       playing;
  logic       new_high;
  logic       died;

  typedef struct {
    logic       is_new;
    int         cyc;
    logic [7:0] hs;
  } pulse_t;

  pulse_t exp_q[$];
  int     cyc    = 0;
  int     last_k = 0;
  int     tests  = 0;
  int     fails  = 0;

  score_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .startGame_s    (start_game),
    .hit_s          (hit),
    .miss_s         (miss),
    .score          (score),
    .highScore      (high_score),
    .lives          (lives),
    .playing_s      (playing),
    .newHighScore_s (new_high),
    .died_s         (died)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest expected event in kind, cycle and highScore.
  always @(negedge clk) begin
    if (new_high || died) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: new=%0b died=%0b at cyc %0d, required no pulse", new_high, died, cyc);
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        if ({new_high, died, cyc, high_score} !== {e.is_new, ~e.is_new, e.cyc, e.hs}) begin
          fails++;
          $display("FAIL pulse: got new=%0b died=%0b cyc=%0d hs=%0d, required new=%0b died=%0b cyc=%0d hs=%0d",
                   new_high, died, cyc, high_score, e.is_new, ~e.is_new, e.cyc, e.hs);
        end
      end
    end
  end

  // Called 5 ns after a posedge; applies inputs for the next edge and returns 5 ns after it.
  task automatic drive(input logic s, input logic h, input logic m);
    start_game = s;
    hit        = h;
    miss       = m;
    @(posedge clk);
    #1;
    last_k = cyc;
    #4;
    start_game = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
  endtask

  task automatic expect_pulse(input logic is_new, input logic [7:0] hs);
    pulse_t e;
    e.is_new = is_new;
    e.cyc    = last_k + 1;
    e.hs     = hs;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulses();
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pulse_timeout: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic play_game(input int hits, input logic is_new, input logic [7:0] hs);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < hits; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    expect_pulse(is_new, hs);
    wait_pulses();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_game = 1'b0;
    hit = 1'b0;
    miss = 1'b0;
    @(posedge clk);
    #5;
    rst = 1'b1;
    tests++;
    if ({score, high_score, lives, playing, new_high, died} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state: score=%0d hs=%0d lives=%0d playing=%0b new=%0b died=%0b, required all 0",
               score, high_score, lives, playing, new_high, died);
    end
  endtask

  task automatic test_first_game();
    logic [1:0] exp_lives;
    drive(1'b1, 1'b0, 1'b0);
    tests++;
    if ({playing, lives, score} !== {1'b1, 2'd3, 8'd0}) begin
      fails++;
      $display("FAIL game_start: playing=%0b lives=%0d score=%0d, required 1 3 0", playing, lives, score);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);
    tests++;
    if (score !== 8'd5) begin
      fails++;
      $display("FAIL five_hits: score=%0d, required 5", score);
    end
    exp_lives = 2'd3;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      exp_lives = exp_lives - 2'd1;
      tests++;
      if (lives !== exp_lives) begin
        fails++;
        $display("FAIL lives_count: lives=%0d, required %0d", lives, exp_lives);
      end
    end
    expect_pulse(1'b1, 8'd5);
    tests++;
    if (playing !== 1'b0) begin
      fails++;
      $display("FAIL check_not_playing: playing=%0b, required 0", playing);
    end
    wait_pulses();
    tests++;
    if ({high_score, score} !== {8'd5, 8'd5}) begin
      fails++;
      $display("FAIL first_high: hs=%0d score=%0d, required 5 5", high_score, score);
    end
  endtask

  task automatic test_lose();
    play_game(3, 1'b0, 8'd5);
    tests++;
    if ({high_score, score} !== {8'd5, 8'd3}) begin
      fails++;
      $display("FAIL lose_low: hs=%0d score=%0d, required 5 3", high_score, score);
    end
    play_game(5, 1'b0, 8'd5);
    tests++;
    if ({high_score, score} !== {8'd5, 8'd5}) begin
      fails++;
      $display("FAIL lose_tie: hs=%0d score=%0d, required 5 5", high_score, score);
    end
  endtask

  task automatic test_saturate();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) drive(1'b0, 1'b1, 1'b0);
    tests++;
    if (score !== 8'd99) begin
      fails++;
      $display("FAIL saturate: score=%0d, required 99", score);
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    expect_pulse(1'b1, 8'd99);
    wait_pulses();
    tests++;
    if ({high_score, score} !== {8'd99, 8'd99}) begin
      fails++;
      $display("FAIL saturate_high: hs=%0d score=%0d, required 99 99", high_score, score);
    end
  endtask

  task automatic test_same_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    play_game(2, 1'b1, 8'd2);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    expect_pulse(1'b1, 8'd3);
    tests++;
    if ({score, lives} !== {8'd3, 2'd0}) begin
      fails++;
      $display("FAIL hit_and_miss: score=%0d lives=%0d, required 3 0", score, lives);
    end
    drive(1'b1, 1'b0, 1'b0);
    tests++;
    if ({playing, score, high_score} !== {1'b0, 8'd3, 8'd3}) begin
      fails++;
      $display("FAIL start_in_check: playing=%0b score=%0d hs=%0d, required 0 3 3", playing, score, high_score);
    end
    wait_pulses();
  endtask

  task automatic test_reset_midgame();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
    tests++;
    if (score !== 8'd4) begin
      fails++;
      $display("FAIL pre_reset_score: score=%0d, required 4", score);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tests++;
    if ({score, high_score, lives, playing, new_high, died} !== 21'd0) begin
      fails++;
      $display("FAIL midgame_reset: score=%0d hs=%0d lives=%0d playing=%0b new=%0b died=%0b, required all 0",
               score, high_score, lives, playing, new_high, died);
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if ({score, lives, playing} !== {8'd0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL idle_ignores: score=%0d lives=%0d playing=%0b, required 0 0 0", score, lives, playing);
    end
    play_game(1, 1'b1, 8'd1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    tests++;
    if ({score, high_score, playing} !== {8'd1, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL over_ignores: score=%0d hs=%0d playing=%0b, required 1 1 0", score, high_score, playing);
    end
  endtask

  initial begin
    test_reset();
    test_first_game();
    test_lose();
    test_saturate();
    test_same_cycle();
    test_reset_midgame();
    drive(1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
